// File: rtl/dma_rx_pkg.sv
// rtl/dma_rx_pkg.sv - shared descriptor type and error bit indices for the RX DMA channel
package dma_rx_pkg;

  typedef struct packed {
    logic [63:6] addr;
    logic [31:6] len;
    logic [31:6] rp;
  } dsc_t;

  localparam int ERR_WR_FULL   = 0;
  localparam int ERR_CMP_EMPTY = 1;

endpackage

// File: rtl/dma_rx_dscq_ram.sv
// rtl/dma_rx_dscq_ram.sv - descriptor storage, one write port and two async read ports
module dma_rx_dscq_ram
  import dma_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  dsc_t          wdata_i,
  input  logic [AW-1:0] iss_addr_i,
  output dsc_t          iss_data_o,
  input  logic [AW-1:0] ret_addr_i,
  output dsc_t          ret_data_o
);

  dsc_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign iss_data_o = mem_q[iss_addr_i];
  assign ret_data_o = mem_q[ret_addr_i];

endmodule

// File: rtl/dma_rx_ch_dscq.sv
// rtl/dma_rx_ch_dscq.sv - per-channel RX descriptor queue with in-order issue and retire
module dma_rx_ch_dscq
  import dma_rx_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        user_clk,
  input  logic        reset_n,
  input  logic        chx_rxch_enb,
  input  logic        chx_rxch_clr_exec,
  input  logic        chx_dscq_we,
  input  logic [63:6] chx_dsc_src_addr,
  input  logic [31:6] chx_dsc_src_len,
  input  logic [31:6] chx_dsc_srbuf_rp_pros,
  output logic        chx_dscq_full,
  output logic        dsc_req_valid,
  input  logic        dsc_req_ready,
  output logic [63:6] dsc_req_addr,
  output logic [31:6] dsc_req_len,
  input  logic        dsc_cmp_valid,
  output logic        chx_que_wt_ack,
  output logic [31:6] chx_que_wt_dscq_src_len,
  output logic [31:6] chx_que_wt_task_id_rp_pros,
  output logic        chx_dscq_busy,
  input  logic        reg_dma_rx_err_1wc,
  output logic [1:0]  chx_set_reg_dma_rx_err_dscq
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW:0]   MAX_P   = PW1'(MAX_OUTSTANDING);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] used, issued, pending, issued_nx;
  logic [PW:0]   inflight;
  logic          drain_q, drain_d;
  logic          req_valid_q, req_valid_d;
  logic [63:6]   req_addr_q, req_addr_d;
  logic [31:6]   req_len_q, req_len_d;
  logic          ack_q, ack_d;
  logic [31:6]   ack_len_q, ack_len_d;
  logic [31:6]   ack_rp_q, ack_rp_d;
  logic [1:0]    err_q, err_d;
  dsc_t          wr_dsc, iss_dsc, ret_dsc, load_dsc;
  logic          full, wr_en, req_accept, can_issue, bypass, load, withdraw;
  logic          cmp_ok, cmp_err;

  assign used    = wr_ptr_q - cm_ptr_q;
  assign issued  = rd_ptr_q - cm_ptr_q;
  assign pending = wr_ptr_q - rd_ptr_q;

  assign full       = (used == DEPTH_P) | drain_q;
  assign wr_en      = chx_dscq_we & ~full & ~chx_rxch_clr_exec;
  assign req_accept = req_valid_q & dsc_req_ready;
  assign inflight   = {1'b0, issued} + {{PW{1'b0}}, req_valid_q};
  assign can_issue  = (~req_valid_q | req_accept) & (inflight < MAX_P)
                    & chx_rxch_enb & ~drain_q & ~chx_rxch_clr_exec;
  // An empty queue forwards the incoming write straight into the request register.
  assign bypass     = can_issue & (pending == '0) & wr_en;
  assign load       = can_issue & ((pending != '0) | wr_en);
  assign withdraw   = chx_rxch_clr_exec & req_valid_q & ~req_accept;
  assign cmp_ok     = dsc_cmp_valid & (issued != '0);
  assign cmp_err    = dsc_cmp_valid & (issued == '0);

  assign wr_dsc   = '{addr: chx_dsc_src_addr, len: chx_dsc_src_len, rp: chx_dsc_srbuf_rp_pros};
  assign load_dsc = bypass ? wr_dsc : iss_dsc;

  dma_rx_dscq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i      (user_clk),
    .we_i       (wr_en),
    .waddr_i    (wr_ptr_q[AW-1:0]),
    .wdata_i    (wr_dsc),
    .iss_addr_i (rd_ptr_q[AW-1:0]),
    .iss_data_o (iss_dsc),
    .ret_addr_i (cm_ptr_q[AW-1:0]),
    .ret_data_o (ret_dsc)
  );

  always_comb begin
    wr_ptr_d = wr_en  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = load   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cm_ptr_d = cmp_ok ? cm_ptr_q + PTR_ONE : cm_ptr_q;
    // Clear drops everything not yet handed to the engine, including a withdrawn request.
    if (chx_rxch_clr_exec) begin
      rd_ptr_d = withdraw ? rd_ptr_q - PTR_ONE : rd_ptr_q;
      wr_ptr_d = rd_ptr_d;
    end
    issued_nx = rd_ptr_d - cm_ptr_d;
    drain_d   = (chx_rxch_clr_exec | drain_q) & (issued_nx != '0);
  end

  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    if (load) begin
      req_valid_d = 1'b1;
      req_addr_d  = load_dsc.addr;
      req_len_d   = load_dsc.len;
    end else if (req_accept | withdraw) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    ack_d     = cmp_ok & ~drain_q;
    ack_len_d = ack_d ? ret_dsc.len : '0;
    ack_rp_d  = ack_d ? ret_dsc.rp  : '0;
    err_d     = reg_dma_rx_err_1wc ? 2'b00 : err_q;
    if (chx_dscq_we & full) begin
      err_d[ERR_WR_FULL] = 1'b1;
    end
    if (cmp_err) begin
      err_d[ERR_CMP_EMPTY] = 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      drain_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      ack_q       <= 1'b0;
      ack_len_q   <= '0;
      ack_rp_q    <= '0;
      err_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      drain_q     <= drain_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      ack_q       <= ack_d;
      ack_len_q   <= ack_len_d;
      ack_rp_q    <= ack_rp_d;
      err_q       <= err_d;
    end
  end

  assign chx_dscq_full               = full;
  assign dsc_req_valid               = req_valid_q;
  assign dsc_req_addr                = req_addr_q;
  assign dsc_req_len                 = req_len_q;
  assign chx_que_wt_ack              = ack_q;
  assign chx_que_wt_dscq_src_len     = ack_len_q;
  assign chx_que_wt_task_id_rp_pros  = ack_rp_q;
  assign chx_dscq_busy               = drain_q | (issued != '0) | req_valid_q;
  assign chx_set_reg_dma_rx_err_dscq = err_q;

endmodule

// File: tb/tb_dma_rx_ch_dscq.sv
// tb/tb_dma_rx_ch_dscq.sv - directed self-checking bench for dma_rx_ch_dscq
module tb_dma_rx_ch_dscq;

  logic        user_clk = 1'b0;
  logic        reset_n;
  logic        chx_rxch_enb;
  logic        chx_rxch_clr_exec;
  logic        chx_dscq_we;
  logic [63:6] chx_dsc_src_addr;
  logic [31:6] chx_dsc_src_len;
  logic [31:6] chx_dsc_srbuf_rp_pros;
  logic        chx_dscq_full;
  logic        dsc_req_valid;
  logic        dsc_req_ready;
  logic [63:6] dsc_req_addr;
  logic [31:6] dsc_req_len;
  logic        dsc_cmp_valid;
  logic        chx_que_wt_ack;
  logic [31:6] chx_que_wt_dscq_src_len;
  logic [31:6] chx_que_wt_task_id_rp_pros;
  logic        chx_dscq_busy;
  logic        reg_dma_rx_err_1wc;
  logic [1:0]  chx_set_reg_dma_rx_err_dscq;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc;
  logic seen;

  always #5 user_clk = ~user_clk;

  dma_rx_ch_dscq #(.DEPTH(8), .MAX_OUTSTANDING(4)) dut (
    .user_clk                    (user_clk),
    .reset_n                     (reset_n),
    .chx_rxch_enb                (chx_rxch_enb),
    .chx_rxch_clr_exec           (chx_rxch_clr_exec),
    .chx_dscq_we                 (chx_dscq_we),
    .chx_dsc_src_addr            (chx_dsc_src_addr),
    .chx_dsc_src_len             (chx_dsc_src_len),
    .chx_dsc_srbuf_rp_pros       (chx_dsc_srbuf_rp_pros),
    .chx_dscq_full               (chx_dscq_full),
    .dsc_req_valid               (dsc_req_valid),
    .dsc_req_ready               (dsc_req_ready),
    .dsc_req_addr                (dsc_req_addr),
    .dsc_req_len                 (dsc_req_len),
    .dsc_cmp_valid               (dsc_cmp_valid),
    .chx_que_wt_ack              (chx_que_wt_ack),
    .chx_que_wt_dscq_src_len     (chx_que_wt_dscq_src_len),
    .chx_que_wt_task_id_rp_pros  (chx_que_wt_task_id_rp_pros),
    .chx_dscq_busy               (chx_dscq_busy),
    .reg_dma_rx_err_1wc          (reg_dma_rx_err_1wc),
    .chx_set_reg_dma_rx_err_dscq (chx_set_reg_dma_rx_err_dscq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge user_clk);
    #1;
  endtask

  task automatic set_wr(input logic [57:0] a, input logic [25:0] l, input logic [25:0] r);
    chx_dscq_we           = 1'b1;
    chx_dsc_src_addr      = a;
    chx_dsc_src_len       = l;
    chx_dsc_srbuf_rp_pros = r;
  endtask

  task automatic do_reset;
    reset_n            = 1'b0;
    chx_dscq_we        = 1'b0;
    dsc_cmp_valid      = 1'b0;
    chx_rxch_clr_exec  = 1'b0;
    reg_dma_rx_err_1wc = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    chx_rxch_enb          = 1'b1;
    dsc_req_ready         = 1'b1;
    chx_dsc_src_addr      = '0;
    chx_dsc_src_len       = '0;
    chx_dsc_srbuf_rp_pros = '0;
    reset_n               = 1'b0;
    chx_dscq_we           = 1'b0;
    dsc_cmp_valid         = 1'b0;
    chx_rxch_clr_exec     = 1'b0;
    reg_dma_rx_err_1wc    = 1'b0;
    tick;
    tick;
    check("rst_full",  chx_dscq_full, 0);
    check("rst_valid", dsc_req_valid, 0);
    check("rst_ack",   chx_que_wt_ack, 0);
    check("rst_alen",  chx_que_wt_dscq_src_len, 0);
    check("rst_busy",  chx_dscq_busy, 0);
    check("rst_err",   chx_set_reg_dma_rx_err_dscq, 0);
    reset_n = 1'b1;
    tick;

    // single descriptor round trip
    set_wr(58'h1000, 26'h10, 26'h10);
    tick;
    chx_dscq_we = 1'b0;
    check("t1_valid", dsc_req_valid, 1);
    check("t1_addr",  dsc_req_addr, 64'h1000);
    check("t1_len",   dsc_req_len, 64'h10);
    tick;
    check("t1_valid_drop", dsc_req_valid, 0);
    check("t1_busy_out",   chx_dscq_busy, 1);
    dsc_cmp_valid = 1'b1;
    tick;
    dsc_cmp_valid = 1'b0;
    check("t1_ack",      chx_que_wt_ack, 1);
    check("t1_ack_len",  chx_que_wt_dscq_src_len, 64'h10);
    check("t1_ack_rp",   chx_que_wt_task_id_rp_pros, 64'h10);
    check("t1_busy_end", chx_dscq_busy, 0);
    tick;
    check("t1_ack_low",  chx_que_wt_ack, 0);
    check("t1_len_zero", chx_que_wt_dscq_src_len, 0);

    // outstanding limit
    do_reset;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_wr(58'h2000 + 58'(i), 26'(i + 1), 26'(32 + i));
      tick;
      if (dsc_req_valid && dsc_req_ready) n_acc++;
    end
    chx_dscq_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (dsc_req_valid && dsc_req_ready) n_acc++;
    end
    check("t2_accepted", 64'(n_acc), 4);
    dsc_cmp_valid = 1'b1;
    tick;
    dsc_cmp_valid = 1'b0;
    check("t2_ack",     chx_que_wt_ack, 1);
    check("t2_ack_len", chx_que_wt_dscq_src_len, 1);
    check("t2_ack_rp",  chx_que_wt_task_id_rp_pros, 32);
    seen = dsc_req_valid;
    if (!seen) begin
      tick;
      seen = dsc_req_valid;
    end
    check("t2_5th_valid", seen, 1);
    check("t2_5th_addr",  dsc_req_addr, 64'h2004);

    // full and overflow with issue disabled
    do_reset;
    chx_rxch_enb = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_wr(58'h3000 + 58'(i), 26'h3, 26'h3);
      tick;
      if (i == 6) check("t3_full_7", chx_dscq_full, 0);
      if (i == 7) check("t3_full_8", chx_dscq_full, 1);
    end
    chx_dscq_we = 1'b0;
    check("t3_err_ovf", chx_set_reg_dma_rx_err_dscq, 2'b01);
    check("t3_no_req",  dsc_req_valid, 0);
    reg_dma_rx_err_1wc = 1'b1;
    tick;
    reg_dma_rx_err_1wc = 1'b0;
    check("t3_err_clr",   chx_set_reg_dma_rx_err_dscq, 0);
    check("t3_full_hold", chx_dscq_full, 1);

    // back-pressure
    do_reset;
    chx_rxch_enb  = 1'b1;
    dsc_req_ready = 1'b0;
    set_wr(58'h4000, 26'h4, 26'h4);
    tick;
    set_wr(58'h4100, 26'h5, 26'h5);
    tick;
    chx_dscq_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", dsc_req_valid, 1);
      check("t4_hold_addr",  dsc_req_addr, 64'h4000);
      check("t4_hold_len",   dsc_req_len, 64'h4);
      tick;
    end
    dsc_req_ready = 1'b1;
    tick;
    check("t4_next_valid", dsc_req_valid, 1);
    check("t4_next_addr",  dsc_req_addr, 64'h4100);
    check("t4_next_len",   dsc_req_len, 64'h5);

    // clear with 2 issued and 3 pending
    do_reset;
    set_wr(58'h5000, 26'h6, 26'h6);
    tick;
    set_wr(58'h5100, 26'h7, 26'h7);
    tick;
    chx_dscq_we = 1'b0;
    tick;
    chx_rxch_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(58'h5200 + 58'(i), 26'h9, 26'h9);
      tick;
    end
    chx_dscq_we = 1'b0;
    check("t5_no_req", dsc_req_valid, 0);
    chx_rxch_clr_exec = 1'b1;
    tick;
    chx_rxch_clr_exec = 1'b0;
    chx_rxch_enb      = 1'b1;
    check("t5_full", chx_dscq_full, 1);
    check("t5_busy", chx_dscq_busy, 1);
    check("t5_req",  dsc_req_valid, 0);
    dsc_cmp_valid = 1'b1;
    tick;
    check("t5_ack1",  chx_que_wt_ack, 0);
    check("t5_busy1", chx_dscq_busy, 1);
    check("t5_full1", chx_dscq_full, 1);
    tick;
    dsc_cmp_valid = 1'b0;
    check("t5_ack2",  chx_que_wt_ack, 0);
    check("t5_busy2", chx_dscq_busy, 0);
    check("t5_full2", chx_dscq_full, 0);
    set_wr(58'h5300, 26'h8, 26'h8);
    tick;
    chx_dscq_we = 1'b0;
    check("t5_new_valid", dsc_req_valid, 1);
    check("t5_new_addr",  dsc_req_addr, 64'h5300);
    check("t5_err",       chx_set_reg_dma_rx_err_dscq, 0);

    // reset mid-operation, then spurious completions
    reset_n = 1'b0;
    #2;
    check("t6_rst_valid", dsc_req_valid, 0);
    check("t6_rst_busy",  chx_dscq_busy, 0);
    tick;
    reset_n = 1'b1;
    tick;
    dsc_cmp_valid = 1'b1;
    tick;
    dsc_cmp_valid = 1'b0;
    check("t6_ack",  chx_que_wt_ack, 0);
    check("t6_err",  chx_set_reg_dma_rx_err_dscq, 2'b10);
    check("t6_busy", chx_dscq_busy, 0);
    dsc_cmp_valid      = 1'b1;
    reg_dma_rx_err_1wc = 1'b1;
    tick;
    dsc_cmp_valid      = 1'b0;
    reg_dma_rx_err_1wc = 1'b0;
    check("t6_set_wins", chx_set_reg_dma_rx_err_dscq, 2'b10);
    reg_dma_rx_err_1wc = 1'b1;
    tick;
    reg_dma_rx_err_1wc = 1'b0;
    check("t6_err_clr", chx_set_reg_dma_rx_err_dscq, 0);
    set_wr(58'h6000, 26'h2, 26'h2);
    tick;
    chx_dscq_we = 1'b0;
    check("t6_req_valid", dsc_req_valid, 1);
    check("t6_req_addr",  dsc_req_addr, 64'h6000);
    check("t6_full",      chx_dscq_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
